hi_res_tdc: RTL and testbench
=============================

Name: hi_res_tdc

Overview:
- Time-to-digital converter. Measures the delay from each rising edge of the asynchronous START reference to each rising edge of the asynchronous STOP pulse.
- Resolution is half a CLK period, obtained by sampling STOP on both CLK edges. In the target system CLK is 250 MHz, so 1 LSB = 2 ns; START is the 40 MHz master clock.
- Sits in the trigger path and time-stamps trigger pulses within the master clock period.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per asynchronous input; minimum 2.
- TIME_W, 8: output width. The coarse counter is TIME_W bits.

Ports:
- CLK  input  1  fast sampling clock; the only clock. Both edges are used.
- RSTb  input  1  reset, synchronous to CLK, active low.
- START  input  1  asynchronous reference; its rising edge opens a measurement frame.
- STOP  input  1  asynchronous event; its rising edge is time-stamped.
- TIME  output  TIME_W  measured interval in half-CLK-period units.
- VALID  output  1  one-cycle strobe; TIME is new in this cycle.

Behaviour:
- Reset: all synchronizer flops 0; coarse counter all-ones (no frame); TIME = 0; VALID = 0. Reset asserted mid-measurement aborts it; no VALID is issued for it.
- START path:
  - START goes through SYNC_STAGES posedge flops, then a rising-edge detector.
  - Pstart is the first CLK posedge that samples START high.
- Coarse counter:
  - Cleared to 0 on the cycle aligned with Pstart.
  - Otherwise increments by 1 per CLK and saturates at all-ones.
  - Value = number of posedges since Pstart.
- STOP paths:
  - Posedge path: STOP sampled on posedge, then SYNC_STAGES-1 further posedge flops.
  - Negedge path: STOP sampled on negedge, retimed on the next posedge, then SYNC_STAGES-1 further posedge flops. It stays pipeline-aligned with the posedge path.
- STOP edge: a rising edge on the posedge path. Pstop is the first posedge that samples STOP high.
  - early = 1 if the negedge sample half a period before Pstop was already high, i.e. STOP arrived in the first half of the cycle.
- Result: TIME = 2*cnt − early.
  - cnt is the counter value aligned with Pstop.
  - Clamp to 0 if negative.
  - Saturate to all-ones if cnt ≥ 2^(TIME_W−1) or the counter is saturated.
  - A STOP before any START after reset gives all-ones.
- Simultaneous START and STOP edges (same aligned cycle): the STOP belongs to the new frame, so cnt = 0 and TIME = 0.
- Multiple STOP edges in one frame: each is measured independently.
- STOP held high: one measurement only; the next requires a low sample first.
- Glitch filter: a STOP pulse seen only by the negedge path is ignored.
- Latency: TIME registered and VALID high exactly SYNC_STAGES+1 CLK cycles after Pstop, for 1 cycle.
- TIME holds its value until the next measurement.
- Minimum STOP spacing: 1 low sample plus 1 high sample. No FIFO; every STOP that meets the spacing yields one strobe.

Test Plan:
- Timing convention: CLK period 4 ns, posedges at 0/4/8…, RSTb held low ≥2 cycles then high, START rises at t = 1 ns (Pstart = 4).
- RSTb low for 4 cycles → TIME = 0 and VALID = 0 throughout; counter reads all-ones afterwards.
- Baseline STOP cases, each a 25 ns pulse:
  - STOP rise at 7 ns → TIME = 2, VALID exactly 3 cycles after posedge 8.
  - STOP rise at 9 ns → TIME = 3 (early = 1).
  - STOP rise at 11 ns → TIME = 4.
  - STOP rise at 15 ns → TIME = 6.
- START as a 40 MHz clock, STOP pulses at +5/+9/+13 ns after successive START edges → TIME values in {1..3}, {3..5}, {5..7}. Exactly one VALID per STOP.
- STOP before any START after reset → TIME = 255, VALID 1 cycle. STOP after START held low for 130 cycles → TIME = 255.
- Corner cases:
  - START and STOP rise in the same aligned cycle → TIME = 0.
  - STOP held high for 100 ns → a single VALID.
  - RSTb asserted between Pstop and VALID → no VALID; TIME = 0.

Source files
------------

// File: rtl/hi_res_tdc.sv
`timescale 1ns/1ps
// Half-period time-to-digital converter: STOP is time-stamped against the last
// START edge using a coarse posedge counter plus a negedge "early" bit.
module hi_res_tdc #(
  parameter int SYNC_STAGES = 2,
  parameter int TIME_W      = 8
) (
  input  logic              CLK,
  input  logic              RSTb,
  input  logic              START,
  input  logic              STOP,
  output logic [TIME_W-1:0] TIME,
  output logic              VALID
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0]      start_sync;
  logic [N-1:0]      stop_pos;
  logic [N-1:0]      stop_neg;
  logic              stop_neg_raw;
  logic              start_d;
  logic              stop_d;
  logic              start_edge;
  logic              stop_edge;
  logic              early;
  logic              res_vld;
  logic [TIME_W-1:0] cnt_reg;
  logic [TIME_W-1:0] cnt_cur;
  logic [TIME_W-1:0] cnt_next;
  logic [TIME_W-1:0] res_reg;
  logic [TIME_W-1:0] res_next;

  // Negedge sample of STOP; retimed into the posedge chain below.
  always_ff @(negedge CLK) begin
    if (!RSTb) stop_neg_raw <= 1'b0;
    else       stop_neg_raw <= STOP;
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      start_sync <= '0;
      stop_pos   <= '0;
      stop_neg   <= '0;
      start_d    <= 1'b0;
      stop_d     <= 1'b0;
      cnt_reg    <= '1;
      res_reg    <= '0;
      res_vld    <= 1'b0;
      TIME       <= '0;
      VALID      <= 1'b0;
    end else begin
      start_sync <= {start_sync[N-2:0], START};
      stop_pos   <= {stop_pos[N-2:0], STOP};
      stop_neg   <= {stop_neg[N-2:0], stop_neg_raw};
      start_d    <= start_sync[N-1];
      stop_d     <= stop_pos[N-1];
      cnt_reg    <= cnt_next;
      res_reg    <= res_next;
      res_vld    <= stop_edge;
      VALID      <= res_vld;
      if (res_vld) TIME <= res_reg;
    end
  end

  always_comb begin
    start_edge = start_sync[N-1] & ~start_d;
    stop_edge  = stop_pos[N-1] & ~stop_d;
    early      = stop_neg[N-1];
    // A STOP aligned with a START edge belongs to the new frame.
    cnt_cur    = start_edge ? '0 : cnt_reg;
    cnt_next   = cnt_reg;
    if (start_edge)    cnt_next = TIME_W'(1);
    else if (~&cnt_reg) cnt_next = cnt_reg + TIME_W'(1);
    res_next = '0;
    if (cnt_cur[TIME_W-1])  res_next = '1;
    else if (cnt_cur != '0) res_next = {cnt_cur[TIME_W-2:0], 1'b0} - TIME_W'(early);
  end

endmodule

// File: tb/tb_hi_res_tdc.sv
`timescale 1ns/1ps
// Directed bench for hi_res_tdc: 4 ns clock, posedges at multiples of 4 ns,
// times below are relative to the posedge where reset is released (t_ref).
module tb_hi_res_tdc;

  logic       CLK;
  logic       RSTb;
  logic       START;
  logic       STOP;
  logic [7:0] TIME;
  logic       VALID;

  int  errors = 0;
  int  checks = 0;
  time t_ref  = 0;
  logic [7:0] v_val[$];
  int         v_at[$];

  hi_res_tdc #(.SYNC_STAGES(2), .TIME_W(8)) dut (
    .CLK(CLK), .RSTb(RSTb), .START(START), .STOP(STOP), .TIME(TIME), .VALID(VALID)
  );

  initial begin
    CLK = 1'b1;
    forever #2 CLK = ~CLK;
  end

  // Records every cycle VALID is high, with the posedge (relative to t_ref) that raised it.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (VALID === 1'b1) begin
        v_val.push_back(TIME);
        v_at.push_back(int'($time - t_ref) - 1);
      end
    end
  end

  task automatic at_rel(input int t);
    if ($time < t_ref + time'(t)) #(t_ref + time'(t) - $time);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RSTb = 1'b0; START = 1'b0; STOP = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1 RSTb = 1'b1;
    @(posedge CLK);
    t_ref = $time;
    v_val.delete();
    v_at.delete();
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RSTb = 1'b0; START = 1'b0; STOP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (TIME !== 8'd0) begin errors++; $display("FAIL reset_time cyc%0d: got %0d expected 0", i, TIME); end
      checks++;
      if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d: got %b expected 0", i, VALID); end
    end
    STOP = 1'b0;
    @(negedge CLK);
    #1 RSTb = 1'b1;
    @(posedge CLK);
    t_ref = $time;
    v_val.delete(); v_at.delete();
    at_rel(40);
    checks++;
    if (v_val.size() != 0) begin errors++; $display("FAIL reset_quiet: got %0d strobes expected 0", v_val.size()); end
  endtask

  task automatic test_stop_before_start;
    do_reset();
    at_rel(7);  STOP = 1'b1;
    at_rel(32); STOP = 1'b0;
    at_rel(60);
    checks++;
    if (v_val.size() != 1) begin errors++; $display("FAIL nostart_count: got %0d expected 1", v_val.size()); end
    else begin
      checks++;
      if (v_val[0] !== 8'd255) begin errors++; $display("FAIL nostart_time: got %0d expected 255", v_val[0]); end
      checks++;
      if (v_at[0] != 20) begin errors++; $display("FAIL nostart_latency: got %0d expected 20", v_at[0]); end
    end
  endtask

  task automatic test_baseline;
    int off[4]    = '{7, 9, 11, 15};
    int exp_t[4]  = '{2, 3, 4, 6};
    int exp_at[4] = '{20, 24, 24, 28};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      at_rel(1);          START = 1'b1;
      at_rel(off[k]);     STOP  = 1'b1;
      at_rel(off[k] + 25); STOP = 1'b0;
      at_rel(80);
      checks++;
      if (v_val.size() != 1) begin errors++; $display("FAIL base%0d_count: got %0d expected 1", off[k], v_val.size()); end
      else begin
        checks++;
        if (v_val[0] !== 8'(exp_t[k])) begin errors++; $display("FAIL base%0d_time: got %0d expected %0d", off[k], v_val[0], exp_t[k]); end
        checks++;
        if (v_at[0] != exp_at[k]) begin errors++; $display("FAIL base%0d_latency: got %0d expected %0d", off[k], v_at[0], exp_at[k]); end
      end
    end
  endtask

  task automatic test_periodic;
    int lo[3] = '{1, 3, 5};
    do_reset();
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          at_rel(1 + 25 * k);  START = 1'b1;
          at_rel(13 + 25 * k); START = 1'b0;
        end
      end
      begin
        at_rel(6);  STOP = 1'b1;
        at_rel(14); STOP = 1'b0;
        at_rel(35); STOP = 1'b1;
        at_rel(43); STOP = 1'b0;
        at_rel(64); STOP = 1'b1;
        at_rel(72); STOP = 1'b0;
      end
    join
    at_rel(140);
    checks++;
    if (v_val.size() != 3) begin errors++; $display("FAIL periodic_count: got %0d expected 3", v_val.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (v_val[k] < 8'(lo[k]) || v_val[k] > 8'(lo[k] + 2)) begin
          errors++;
          $display("FAIL periodic%0d_time: got %0d expected %0d..%0d", k, v_val[k], lo[k], lo[k] + 2);
        end
      end
    end
  endtask

  task automatic test_saturation;
    int off[4]   = '{509, 511, 515, 523};
    int exp_t[4] = '{253, 254, 255, 255};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      at_rel(1);           START = 1'b1;
      at_rel(off[k]);      STOP  = 1'b1;
      at_rel(off[k] + 20); STOP  = 1'b0;
      at_rel(off[k] + 40);
      checks++;
      if (v_val.size() != 1) begin errors++; $display("FAIL sat%0d_count: got %0d expected 1", off[k], v_val.size()); end
      else begin
        checks++;
        if (v_val[0] !== 8'(exp_t[k])) begin errors++; $display("FAIL sat%0d_time: got %0d expected %0d", off[k], v_val[0], exp_t[k]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    at_rel(1);  START = 1'b1;
    at_rel(7);  STOP  = 1'b1;
    at_rel(11); STOP  = 1'b0;
    at_rel(13); STOP  = 1'b1;
    at_rel(17); STOP  = 1'b0;
    at_rel(60);
    checks++;
    if (v_val.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", v_val.size()); end
    else begin
      checks++;
      if (v_val[0] !== 8'd2) begin errors++; $display("FAIL b2b_first: got %0d expected 2", v_val[0]); end
      checks++;
      if (v_val[1] !== 8'd5) begin errors++; $display("FAIL b2b_second: got %0d expected 5", v_val[1]); end
      checks++;
      if (v_at[0] != 20 || v_at[1] != 28) begin errors++; $display("FAIL b2b_latency: got %0d,%0d expected 20,28", v_at[0], v_at[1]); end
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    at_rel(1);  START = 1'b1; STOP = 1'b1;
    at_rel(26); STOP  = 1'b0;
    at_rel(60);
    checks++;
    if (v_val.size() != 1) begin errors++; $display("FAIL simul_count: got %0d expected 1", v_val.size()); end
    else begin
      checks++;
      if (v_val[0] !== 8'd0) begin errors++; $display("FAIL simul_time: got %0d expected 0", v_val[0]); end
    end
  endtask

  task automatic test_held_high;
    do_reset();
    at_rel(1);   START = 1'b1;
    at_rel(7);   STOP  = 1'b1;
    at_rel(107); STOP  = 1'b0;
    at_rel(160);
    checks++;
    if (v_val.size() != 1) begin errors++; $display("FAIL held_count: got %0d expected 1", v_val.size()); end
    else begin
      checks++;
      if (v_val[0] !== 8'd2) begin errors++; $display("FAIL held_time: got %0d expected 2", v_val[0]); end
    end
  endtask

  task automatic test_glitch;
    do_reset();
    at_rel(1);  START = 1'b1;
    at_rel(9);  STOP  = 1'b1;
    at_rel(11); STOP  = 1'b0;
    at_rel(27); STOP  = 1'b1;
    at_rel(40); STOP  = 1'b0;
    at_rel(80);
    checks++;
    if (v_val.size() != 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", v_val.size()); end
    else begin
      checks++;
      if (v_val[0] !== 8'd12) begin errors++; $display("FAIL glitch_time: got %0d expected 12", v_val[0]); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    at_rel(1);  START = 1'b1;
    at_rel(7);  STOP  = 1'b1;
    at_rel(11); STOP  = 1'b0;
    at_rel(27); STOP  = 1'b1;
    at_rel(33); RSTb  = 1'b0;
    at_rel(35); STOP  = 1'b0;
    at_rel(45); RSTb  = 1'b1;
    at_rel(100);
    checks++;
    if (v_val.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", v_val.size()); end
    else begin
      checks++;
      if (v_val[0] !== 8'd2) begin errors++; $display("FAIL rstmid_first: got %0d expected 2", v_val[0]); end
    end
    checks++;
    if (TIME !== 8'd0) begin errors++; $display("FAIL rstmid_time: got %0d expected 0", TIME); end
  endtask

  initial begin
    RSTb = 1'b0; START = 1'b0; STOP = 1'b0;
    test_reset();
    test_stop_before_start();
    test_baseline();
    test_periodic();
    test_saturation();
    test_back_to_back();
    test_simultaneous();
    test_held_high();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
